// File: rtl/arbitro_compuerta.sv
// Two-lane round-robin arbiter for a single parking gate controller, with lot occupancy tracking.
// Optional CONCEDIDO timeout abort enabled by defining ARBITRO_TIMEOUT_EN.
module arbitro_compuerta #(
  parameter int CAPACIDAD  = 16,
  parameter int ANCHO_CONT = 5,
  parameter int TIMEOUT    = 255,
  parameter int ANCHO_TO   = 8
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [1:0]            Solicitud,
  input  logic [1:0]            Pin_in,
  input  logic [1:0]            Paso,
  input  logic                  Abierto_c,
  input  logic                  Cerrado_c,
  input  logic                  Bloqueo_c,
  output logic                  Vehiculo_c,
  output logic                  Pin_c,
  output logic                  Termino_c,
  output logic [1:0]            Concedido,
  output logic                  Lleno,
  output logic [ANCHO_CONT-1:0] Ocupacion,
  output logic                  Error_to
);

  typedef enum logic [2:0] {LIBRE, CONCEDIDO, CRUZANDO, LIBERANDO, BLOQUEADO} estado_t;

  localparam logic [ANCHO_CONT-1:0] CAP = ANCHO_CONT'(CAPACIDAD);

  if (2 ** ANCHO_CONT <= CAPACIDAD) begin : g_chk_cont
    $error("ANCHO_CONT too narrow for CAPACIDAD");
  end
  if (TIMEOUT < 1 || TIMEOUT >= 2 ** ANCHO_TO) begin : g_chk_to
    $error("TIMEOUT does not fit in ANCHO_TO bits");
  end

  estado_t               estado, estado_n;
  logic                  puntero, puntero_n;  // lane favoured when both are eligible
  logic                  lado, lado_n;        // currently granted lane
  logic [1:0]            conc_n;
  logic                  veh_n, pin_n, ter_n, lleno_n, err_n;
  logic [ANCHO_CONT-1:0] ocup_n;
  logic                  elig0, elig1;

  assign elig0 = Solicitud[0] && !Lleno;
  assign elig1 = Solicitud[1] && (Ocupacion != '0);

`ifdef ARBITRO_TIMEOUT_EN
  localparam logic [ANCHO_TO-1:0] TO_FIN = ANCHO_TO'(TIMEOUT - 1);
  logic [ANCHO_TO-1:0] cont, cont_n;
`else
  assign Error_to = 1'b0;
`endif

  // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      estado     <= LIBRE;
      puntero    <= 1'b0;
      lado       <= 1'b0;
      Concedido  <= 2'b00;
      Vehiculo_c <= 1'b0;
      Pin_c      <= 1'b0;
      Termino_c  <= 1'b0;
      Ocupacion  <= '0;
      Lleno      <= 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
      cont       <= '0;
      Error_to   <= 1'b0;
`endif
    end else begin
      estado     <= estado_n;
      puntero    <= puntero_n;
      lado       <= lado_n;
      Concedido  <= conc_n;
      Vehiculo_c <= veh_n;
      Pin_c      <= pin_n;
      Termino_c  <= ter_n;
      Ocupacion  <= ocup_n;
      Lleno      <= lleno_n;
`ifdef ARBITRO_TIMEOUT_EN
      cont       <= cont_n;
      Error_to   <= err_n;
`endif
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    estado_n  = estado;
    puntero_n = puntero;
    lado_n    = lado;
    conc_n    = Concedido;
    veh_n     = Vehiculo_c;
    pin_n     = 1'b0;
    ter_n     = 1'b0;
    ocup_n    = Ocupacion;
    err_n     = 1'b0;
`ifdef ARBITRO_TIMEOUT_EN
    cont_n    = cont;
`endif
    case (estado)
      LIBRE: begin
        if (elig0 || elig1) begin
          lado_n   = (elig0 && elig1) ? puntero : elig1;
          conc_n   = lado_n ? 2'b10 : 2'b01;
          veh_n    = 1'b1;
          estado_n = CONCEDIDO;
`ifdef ARBITRO_TIMEOUT_EN
          cont_n   = '0;
`endif
        end
      end
      CONCEDIDO: begin
        pin_n = Pin_in[lado];
`ifdef ARBITRO_TIMEOUT_EN
        cont_n = cont + 1'b1;
`endif
        if (Bloqueo_c) begin
          pin_n    = 1'b0;
          conc_n   = 2'b00;
          veh_n    = 1'b0;
          estado_n = BLOQUEADO;
        end else if (Abierto_c) begin
          estado_n = CRUZANDO;
        end else if (!Solicitud[lado]) begin
          conc_n   = 2'b00;
          veh_n    = 1'b0;
          estado_n = LIBERANDO;
`ifdef ARBITRO_TIMEOUT_EN
        end else if (cont == TO_FIN) begin
          err_n    = 1'b1;
          conc_n   = 2'b00;
          veh_n    = 1'b0;
          estado_n = LIBERANDO;
`endif
        end
      end
      CRUZANDO: begin
        if (Paso[lado]) begin
          ter_n = 1'b1;
          if (!lado && Ocupacion != CAP)     ocup_n = Ocupacion + 1'b1;
          else if (lado && Ocupacion != '0)  ocup_n = Ocupacion - 1'b1;
          conc_n   = 2'b00;
          veh_n    = 1'b0;
          estado_n = LIBERANDO;
        end
      end
      LIBERANDO: begin
        conc_n = 2'b00;
        veh_n  = 1'b0;
        if (Cerrado_c) begin
          puntero_n = !lado;
          estado_n  = LIBRE;
        end
      end
      BLOQUEADO: begin
        conc_n = 2'b00;
        veh_n  = 1'b0;
        if (!Bloqueo_c) estado_n = LIBERANDO;
      end
      default: estado_n = LIBRE;
    endcase
    lleno_n = (ocup_n == CAP);
  end

endmodule

// File: tb/tb_arbitro_compuerta.sv
// Self-checking bench for arbitro_compuerta: directed vector table plus multi-cycle sequences.
module tb_arbitro_compuerta;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [1:0] Solicitud, Pin_in, Paso;
  logic       Abierto_c, Cerrado_c, Bloqueo_c;
  logic       Vehiculo_c, Pin_c, Termino_c, Lleno, Error_to;
  logic [1:0] Concedido;
  logic [4:0] Ocupacion;

  int checks = 0;
  int errors = 0;
  int exp_ocup = 0;

  arbitro_compuerta dut (
    .Clk(Clk), .Reset(Reset), .Solicitud(Solicitud), .Pin_in(Pin_in), .Paso(Paso),
    .Abierto_c(Abierto_c), .Cerrado_c(Cerrado_c), .Bloqueo_c(Bloqueo_c),
    .Vehiculo_c(Vehiculo_c), .Pin_c(Pin_c), .Termino_c(Termino_c), .Concedido(Concedido),
    .Lleno(Lleno), .Ocupacion(Ocupacion), .Error_to(Error_to)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0] sol, pin, paso;
    logic       ab, ce, bl;
    logic [1:0] conc;
    logic       veh, pinc, ter;
    logic [4:0] ocup;
    logic       lleno;
  } vec_t;

  vec_t vt [22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [11:0] salidas();
    return {Concedido, Vehiculo_c, Pin_c, Termino_c, Lleno, Ocupacion, Error_to};
  endfunction

  // One complete grant/cross/release cycle for the given lane; ends back in LIBRE.
  task automatic ciclo(input logic [1:0] sol, input int lane);
    logic [1:0] oh;
    oh = (lane == 1) ? 2'b10 : 2'b01;
    Solicitud = sol;
    tick;
    check("grant", Concedido, oh);
    Abierto_c = 1'b1;
    tick;
    Abierto_c = 1'b0;
    Paso = oh;
    tick;
    Paso = 2'b00;
    if (lane == 0 && exp_ocup < 16) exp_ocup++;
    else if (lane == 1 && exp_ocup > 0) exp_ocup--;
    check("cruce", {Termino_c, Ocupacion, Lleno, Concedido},
          {1'b1, 5'(exp_ocup), (exp_ocup == 16), 2'b00});
    Cerrado_c = 1'b1;
    tick;
    Cerrado_c = 1'b0;
  endtask

  initial begin
    int k;
    int nerr;
    //        sol    pin    paso   ab ce bl  conc  veh pc tr ocup  ll
    vt[0]  = '{2'b01, 2'b00, 2'b00, 0, 0, 0, 2'b01, 1, 0, 0, 5'd0, 0};
    vt[1]  = '{2'b01, 2'b01, 2'b00, 0, 0, 0, 2'b01, 1, 1, 0, 5'd0, 0};
    vt[2]  = '{2'b01, 2'b10, 2'b00, 0, 0, 0, 2'b01, 1, 0, 0, 5'd0, 0};
    vt[3]  = '{2'b01, 2'b00, 2'b00, 1, 0, 0, 2'b01, 1, 0, 0, 5'd0, 0};
    vt[4]  = '{2'b01, 2'b00, 2'b10, 1, 0, 0, 2'b01, 1, 0, 0, 5'd0, 0};
    vt[5]  = '{2'b01, 2'b00, 2'b01, 0, 0, 0, 2'b00, 0, 0, 1, 5'd1, 0};
    vt[6]  = '{2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'd1, 0};
    vt[7]  = '{2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 5'd1, 0};
    vt[8]  = '{2'b00, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'd1, 0};
    vt[9]  = '{2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b10, 1, 0, 0, 5'd1, 0};
    vt[10] = '{2'b11, 2'b00, 2'b00, 1, 0, 1, 2'b00, 0, 0, 0, 5'd1, 0};
    vt[11] = '{2'b11, 2'b10, 2'b00, 0, 0, 1, 2'b00, 0, 0, 0, 5'd1, 0};
    vt[12] = '{2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'd1, 0};
    vt[13] = '{2'b11, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 5'd1, 0};
    vt[14] = '{2'b11, 2'b00, 2'b00, 0, 0, 0, 2'b01, 1, 0, 0, 5'd1, 0};
    vt[15] = '{2'b10, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'd1, 0};
    vt[16] = '{2'b10, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 5'd1, 0};
    vt[17] = '{2'b10, 2'b00, 2'b00, 0, 0, 0, 2'b10, 1, 0, 0, 5'd1, 0};
    vt[18] = '{2'b10, 2'b00, 2'b00, 1, 0, 0, 2'b10, 1, 0, 0, 5'd1, 0};
    vt[19] = '{2'b10, 2'b00, 2'b10, 0, 0, 0, 2'b00, 0, 0, 1, 5'd0, 0};
    vt[20] = '{2'b00, 2'b00, 2'b00, 0, 1, 0, 2'b00, 0, 0, 0, 5'd0, 0};
    vt[21] = '{2'b10, 2'b00, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 5'd0, 0};

    Reset = 1'b0;
    Solicitud = 2'b00; Pin_in = 2'b00; Paso = 2'b00;
    Abierto_c = 1'b0; Cerrado_c = 1'b0; Bloqueo_c = 1'b0;
    tick;
    tick;
    check("reset", salidas(), 12'h000);
    Reset = 1'b1;

    // Entrance cycle, lockout, exit and eligibility vectors.
    for (int i = 0; i < 22; i++) begin
      Solicitud = vt[i].sol; Pin_in = vt[i].pin; Paso = vt[i].paso;
      Abierto_c = vt[i].ab; Cerrado_c = vt[i].ce; Bloqueo_c = vt[i].bl;
      tick;
      check($sformatf("vec%0d", i), salidas(),
            {vt[i].conc, vt[i].veh, vt[i].pinc, vt[i].ter, vt[i].lleno, vt[i].ocup, 1'b0});
    end
    Solicitud = 2'b00; Pin_in = 2'b00; Paso = 2'b00;
    Abierto_c = 1'b0; Cerrado_c = 1'b0; Bloqueo_c = 1'b0;
    exp_ocup = 0;

    // Reach occupancy 3 with the pointer back on lane 0, then hold both requests.
    for (int i = 0; i < 4; i++) ciclo(2'b01, 0);
    ciclo(2'b10, 1);
    ciclo(2'b11, 0);
    ciclo(2'b11, 1);
    ciclo(2'b11, 0);

    // Fill the lot, confirm entrance is refused, then let one vehicle out.
    for (int i = 0; i < 12; i++) ciclo(2'b01, 0);
    Solicitud = 2'b01;
    for (int i = 0; i < 3; i++) begin
      tick;
      check("lleno_sin_grant", {Concedido, Lleno, Ocupacion}, {2'b00, 1'b1, 5'd16});
    end
    ciclo(2'b11, 1);

    // Asynchronous reset in the middle of a crossing.
    Solicitud = 2'b01;
    tick;
    Abierto_c = 1'b1;
    tick;
    Abierto_c = 1'b0;
    Paso = 2'b01;
    #2 Reset = 1'b0;
    #1 check("reset_async", salidas(), 12'h000);
    tick;
    Paso = 2'b00;
    Solicitud = 2'b00;
    Reset = 1'b1;
    tick;
    check("post_reset", salidas(), 12'h000);
    Solicitud = 2'b01;
    tick;
    check("post_reset_grant", {Concedido, Vehiculo_c, Ocupacion}, {2'b01, 1'b1, 5'd0});
    Solicitud = 2'b00;
    tick;
    Cerrado_c = 1'b1;
    tick;
    Cerrado_c = 1'b0;

    // Grant with no gate response: timeout abort or indefinite wait.
    Solicitud = 2'b01;
    tick;
    check("to_grant", Concedido, 2'b01);
`ifdef ARBITRO_TIMEOUT_EN
    k = 0;
    for (int i = 1; i <= 300 && k == 0; i++) begin
      tick;
      if (Error_to) k = i;
    end
    check("to_ciclos", k, 255);
    check("to_estado", {Concedido, Ocupacion}, {2'b00, 5'd0});
    tick;
    check("to_pulso", Error_to, 1'b0);
`else
    nerr = 0;
    for (int i = 0; i < 300; i++) begin
      tick;
      if (Error_to) nerr++;
    end
    check("sin_to_error", nerr, 0);
    check("sin_to_espera", {Concedido, Vehiculo_c}, {2'b01, 1'b1});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/arbitro_compuerta.md
# arbitro_compuerta

- Arbitrates the single parking gate controller between two lanes: entrance (lane 0) and exit (lane 1).
- Grants the gate to one lane at a time with round-robin fairness.
- Forwards the granted lane's vehicle, PIN and crossing signals to the gate controller, and watches the controller's `Abierto`, `Cerrado` and `Bloqueo` status.
- Keeps the lot occupancy count and refuses entrance when the lot is full.

## Interface
Parameters:
- `CAPACIDAD`, default 16: lot capacity in vehicles.
- `ANCHO_CONT`, default 5: width of `Ocupacion`. Must satisfy 2^ANCHO_CONT > CAPACIDAD.
- `TIMEOUT`, default 255: maximum cycles in CONCEDIDO before abort.
- `ANCHO_TO`, default 8: width of the timeout counter.

Ports:
- `Clk` in 1: single clock. All logic is on the rising edge.
- `Reset` in 1: asynchronous, active-low reset.
- `Solicitud` in 2: vehicle present. Bit 0 is the entrance, bit 1 is the exit. Level signal.
- `Pin_in` in 2: per-lane valid-PIN pulse.
- `Paso` in 2: per-lane pulse meaning the vehicle finished crossing.
- `Abierto_c` in 1: gate open, from the gate controller.
- `Cerrado_c` in 1: gate closed, from the gate controller.
- `Bloqueo_c` in 1: gate controller is in lockout.
- `Vehiculo_c` out 1: vehicle-present signal to the controller.
- `Pin_c` out 1: PIN pulse to the controller.
- `Termino_c` out 1: crossing-finished pulse to the controller.
- `Concedido` out 2: one-hot grant, or 0 when no lane is granted.
- `Lleno` out 1: high when `Ocupacion` == CAPACIDAD.
- `Ocupacion` out ANCHO_CONT: vehicles currently inside.
- `Error_to` out 1: one-cycle pulse on timeout abort.

## Operation
- **Outputs:** all outputs are registered.
- **Reset values:** all outputs are 0. State = LIBRE. Round-robin pointer = lane 0. Timeout counter = 0.
- **Eligibility:**
  - Lane 0 is eligible when `Solicitud[0]` and not `Lleno`.
  - Lane 1 is eligible when `Solicitud[1]` and `Ocupacion` != 0.
- **FSM states:**
  - **LIBRE**
    - One eligible lane: grant it.
    - Both eligible: grant the lane the pointer favours.
    - On a grant: `Concedido` = one-hot and `Vehiculo_c` = 1 from the next cycle; go to CONCEDIDO.
  - **CONCEDIDO**
    - `Pin_c` = `Pin_in[g]` with one-cycle latency. `Pin_in` on the non-granted lane is ignored.
    - `Bloqueo_c` = 1 → go to BLOQUEADO. This has priority over `Abierto_c`.
    - `Abierto_c` = 1 → go to CRUZANDO.
    - `Solicitud[g]` dropping → go to LIBERANDO.
  - **CRUZANDO**
    - On `Paso[g]`: pulse `Termino_c` for 1 cycle.
    - In the same cycle, `Ocupacion` +1 for lane 0 or −1 for lane 1. The count saturates at CAPACIDAD and at 0.
    - Go to LIBERANDO.
    - `Paso` on the other lane is ignored.
  - **LIBERANDO**
    - `Vehiculo_c` = 0 and `Concedido` = 0.
    - Wait for `Cerrado_c` = 1.
    - Then the pointer moves to the other lane; go to LIBRE.
  - **BLOQUEADO**
    - `Concedido` = 0, `Vehiculo_c` = 0, `Pin_c` = 0.
    - When `Bloqueo_c` falls → go to LIBERANDO.
    - The pointer still moves to the other lane.
- **Lleno:** recomputed from the updated `Ocupacion` in the same cycle the count changes.

## Timing
- **Grant latency:** `Solicitud` sampled in LIBRE → `Concedido` and `Vehiculo_c` high on the next edge.
- **PIN:** `Pin_in[g]` at edge n → `Pin_c` high at edge n+1, for 1 cycle per input cycle.
- **Crossing:** `Paso[g]` at edge n → `Termino_c` high and `Ocupacion` updated at edge n+1.
- **Release:** LIBRE is re-entered 1 cycle after `Cerrado_c` is seen in LIBERANDO. A new grant is possible 1 cycle after that.
- **Simultaneous requests:** when both lanes request in LIBRE, the pointer decides. A lane that just finished cannot win the next contest while the other lane is eligible.
- **Reset mid-operation:** outputs clear immediately and asynchronously. An in-progress crossing is not counted.

## Configuration
- Macro: `ARBITRO_TIMEOUT_EN`.
- **Defined:**
  - The counter runs only in CONCEDIDO and clears on entry.
  - When it reaches TIMEOUT with no `Abierto_c`, `Bloqueo_c` or `Solicitud[g]` drop, `Error_to` pulses 1 cycle and the FSM goes to LIBERANDO.
- **Undefined:**
  - There is no counter.
  - CONCEDIDO waits indefinitely.
  - `Error_to` is tied to 0.

## Test plan
- **Reset:** `Reset` = 0 mid-CRUZANDO → all outputs 0, `Ocupacion` = 0, state LIBRE.
- **Entrance cycle:** `Solicitud` = 01, `Pin_in[0]` pulse, `Abierto_c` = 1, `Paso[0]` pulse, then `Cerrado_c` = 1 → `Concedido` = 01, `Pin_c` pulse, `Termino_c` pulse, `Ocupacion` = 1, back in LIBRE.
- **Round-robin:** `Solicitud` = 11 held with `Ocupacion` = 3 → grants alternate 01, 10, 01. `Ocupacion` goes 4, 3, 4.
- **Full lot:** `Ocupacion` = 16 and `Solicitud` = 01 → `Lleno` = 1 and no grant. Adding `Solicitud[1]` → grant 10; after the crossing, `Ocupacion` = 15 and `Lleno` = 0.
- **Lockout:** `Bloqueo_c` = 1 in CONCEDIDO → `Concedido` = 00 and `Vehiculo_c` = 0. When `Bloqueo_c` falls and `Cerrado_c` = 1 → LIBRE and the pointer favours the other lane.
- **Timeout** (`ARBITRO_TIMEOUT_EN` defined, TIMEOUT = 255): grant with no `Abierto_c` → `Error_to` pulses once 255 cycles after CONCEDIDO entry and `Ocupacion` is unchanged.
